pipe_stage_skid: RTL
====================

# pipe_stage_skid

Parametrised pipeline stage register with valid/ready flow control, an optional two-entry skid buffer, and a synchronous flush. It is the general replacement for the fixed-field, always-advancing stage registers between core pipeline stages. Stages can stall on back-pressure and be squashed on redirect without losing or duplicating a transfer. Payload is split into a data field and a control field; the control field is forced to zero whenever the stage holds no valid entry, so write-enables never fire from a bubble.

## Interface
- DATA_W, 32: width of the data payload (results, PCs, load data).
- CTRL_W, 8: width of the control payload (write-enables, result-select, rd); zeroed when invalid.
- SKID, 1: 1 selects the two-entry skid buffer with registered in_ready; 0 selects a single entry with combinational in_ready.

- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- flush  input  1  squash all held entries; synchronous.
- in_valid  input  1  upstream offers a transfer.
- in_ready  output  1  stage accepts a transfer this cycle.
- in_data  input  DATA_W  upstream data payload.
- in_ctrl  input  CTRL_W  upstream control payload.
- out_valid  output  1  stage presents a transfer.
- out_ready  input  1  downstream accepts this cycle.
- out_data  output  DATA_W  presented data payload.
- out_ctrl  output  CTRL_W  presented control payload; all zero when out_valid=0.
- occupancy  output  2  number of held entries (0..2; max 1 when SKID=0).

## Operation
- Handshakes:
  - An input handshake is in_valid && in_ready.
  - An output handshake is out_valid && out_ready.
  - in_valid must not depend combinationally on in_ready.
- Storage:
  - Main register M drives out_data/out_ctrl.
  - Skid register S exists only when SKID=1.
  - Order is strictly FIFO.
- States: EMPTY (occupancy 0), FULL (1), SKID2 (2; SKID=1 only).
- EMPTY:
  - in_ready=1, out_valid=0.
  - Input handshake: M <= in, go to FULL.
- FULL:
  - out_valid=1.
  - in_ready is 1 when SKID=1; it is out_ready when SKID=0.
  - Input and output handshake: M <= in, stay FULL.
  - Output handshake only: go to EMPTY.
  - Input handshake only (SKID=1): S <= in, go to SKID2.
  - Neither: hold.
- SKID2:
  - in_ready=0, out_valid=1.
  - Output handshake: M <= S, go to FULL.
  - Otherwise hold.
- in_ready when SKID=1 is a pure function of the state flop (no combinational path from out_ready).
- out_valid is always a pure function of the state flop.
- out_ctrl = out_valid ? M.ctrl : 0.
- out_data holds its last loaded value when out_valid=0.
- flush:
  - Next state is EMPTY.
  - Any input handshake in the same cycle is discarded. in_ready still reads per the current state.
  - An output handshake in the flush cycle still completes, because downstream has already sampled it.
  - M.data and S are not cleared.
- Priority: rst > flush > normal operation.

## Timing
- Reset values:
  - state EMPTY, out_valid 0, out_data 0, out_ctrl 0, occupancy 0.
  - in_ready 1 from the first cycle after rst deasserts.
  - Inputs presented while rst=1 are discarded.
- Reset asserted mid-transfer drops all held entries; nothing is emitted afterwards.
- Latency: an input handshake in cycle N gives out_valid=1 with that payload in cycle N+1.
- Throughput: one transfer per cycle while out_ready=1, in both SKID modes.
- Back-pressure:
  - SKID=1 absorbs exactly one extra transfer after out_ready falls. in_ready drops the following cycle.
  - SKID=0 drops in_ready in the same cycle.
- Full-to-drain: leaving SKID2 takes one output handshake. in_ready returns to 1 the cycle after.
- Flush: out_valid=0 and out_ctrl=0 in cycle N+1 after flush in cycle N. A new input can be accepted in N+1.

## Test plan
- Streaming: in_valid=1, out_ready=1, in_data=1,2,3,4 on consecutive cycles. Expect out_data 1,2,3,4 in cycles N+1..N+4, occupancy=1 throughout, in_ready=1.
- Stall and skid (SKID=1):
  - Stimulus: send A=0xA, B=0xB; out_ready=0 from the cycle A first appears.
  - Expect: B is captured in S, occupancy=2, in_ready=0 next cycle.
  - Then raise out_ready; expect A then B, with no loss or duplication.
- Stall (SKID=0):
  - Stimulus: out_ready=0 while FULL.
  - Expect: in_ready=0 in the same cycle; a held input is not accepted until out_ready=1. Then M is replaced and a new transfer issues every cycle.
- Flush:
  - Stimulus: in SKID2 holding in_ctrl=0xFF entries, assert flush with in_valid=1.
  - Expect: next cycle out_valid=0, out_ctrl=0x00, occupancy=0, and the flushed-cycle input absent.
- Reset mid-operation:
  - Stimulus: rst=1 while occupancy=2.
  - Expect: next cycle out_valid=0, out_data=0, out_ctrl=0, occupancy=0, and in_ready=1 after rst falls.
- Bubble gating: in_ctrl=0xFF with in_valid=0 for 3 cycles. Expect out_ctrl=0x00 and out_valid=0 throughout.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline stage, optional 2-entry skid, flush.
// Ports: clk/rst, flush, in_* upstream, out_* downstream, occupancy count.
module pipe_stage_skid #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter bit SKID   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  // Encoding equals the number of held entries.
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] FULL  = 2'd1;
  localparam logic [1:0] SKID2 = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d;
  logic [DATA_W-1:0] s_data_q, s_data_d;
  logic [CTRL_W-1:0] s_ctrl_q, s_ctrl_d;
  logic              in_hs;
  logic              out_hs;

  assign out_valid = (state_q != EMPTY);
  assign out_data  = m_data_q;
  assign out_ctrl  = out_valid ? m_ctrl_q
                               : '0;
  assign occupancy = state_q;

  // Without skid the only free slot while FULL
  // is the one being drained this cycle.
  always_comb begin
    in_ready = 1'b0;
    unique case (state_q)
      EMPTY:   in_ready = 1'b1;
      FULL:    in_ready = SKID ? 1'b1
                               : out_ready;
      default: in_ready = 1'b0;
    endcase
  end

  assign in_hs  = in_valid && in_ready;
  assign out_hs = out_valid && out_ready;

  always_comb begin
    state_d  = state_q;
    m_data_d = m_data_q;
    m_ctrl_d = m_ctrl_q;
    s_data_d = s_data_q;
    s_ctrl_d = s_ctrl_q;
    if (flush) begin
      // Held payload stays; only the state drops,
      // so out_data keeps its last value.
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_hs) begin
            m_data_d = in_data;
            m_ctrl_d = in_ctrl;
            state_d  = FULL;
          end
        end
        FULL: begin
          if (in_hs && out_hs) begin
            m_data_d = in_data;
            m_ctrl_d = in_ctrl;
          end else if (out_hs) begin
            state_d = EMPTY;
          end else if (in_hs && SKID) begin
            s_data_d = in_data;
            s_ctrl_d = in_ctrl;
            state_d  = SKID2;
          end
        end
        SKID2: begin
          if (out_hs) begin
            m_data_d = s_data_q;
            m_ctrl_d = s_ctrl_q;
            state_d  = FULL;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= EMPTY;
      m_data_q <= '0;
      m_ctrl_q <= '0;
      s_data_q <= '0;
      s_ctrl_q <= '0;
    end else begin
      state_q  <= state_d;
      m_data_q <= m_data_d;
      m_ctrl_q <= m_ctrl_d;
      s_data_q <= s_data_d;
      s_ctrl_q <= s_ctrl_d;
    end
  end

endmodule
